// File: rtl/fsm_rx.sv
// fsm_rx -- serial receiver for the one-bit-per-clock link driven by the `fsm`
// transmitter. It waits for a start bit, shifts in DATA_BITS data bits LSB
// first, then checks the stop bit. A good frame updates `data` and pulses
// `valid`. A bad frame pulses `frame_err` and bumps a saturating error count.
//
// Ports:
//   clk        system clock; every sample is taken on the rising edge
//   rst        asynchronous, active-low reset; clears all state immediately
//   rxd        serial line, synchronous to clk
//              (idle 0, start 1, data LSB first, stop 0)
//   data       last good received word; held until the next good frame
//   valid      one-cycle strobe: data was just updated by a good frame
//   frame_err  one-cycle strobe: the stop bit was sampled as 1
//   busy       high while a frame is in progress (DATA and STOP)
//   err_cnt    framing error count; saturates at 255
//   state_dbg  current FSM state, for debug and checker binding
//              (0 IDLE, 1 DATA, 2 STOP, 3 RESYNC)
//
// Strobe semantics: there is no ready/backpressure.
// - `valid` is high for exactly one cycle, and `data` is stable and meaningful
//   in that cycle (and after it, until the next good frame).
// - `frame_err` is high for exactly one cycle, and never together with `valid`.
// - A consumer that misses a strobe loses that event.
module fsm_rx #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy,
    output logic [7:0]           err_cnt,
    output logic [1:0]           state_dbg
);

    localparam int CNT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        STOP   = 2'd2,
        RESYNC = 2'd3
    } state_t;

    state_t               state;
    logic [DATA_BITS-1:0] shreg;
    logic [CNT_W-1:0]     bit_cnt;

    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            // Both strobes default low, so each one lasts exactly one cycle.
            valid     <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rxd) begin
                        bit_cnt <= '0;
                        busy    <= 1'b1;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    shreg[bit_cnt] <= rxd;
                    bit_cnt        <= bit_cnt + CNT_W'(1);
                    if (bit_cnt == LAST_BIT) begin
                        state <= STOP;
                    end
                end
                STOP: begin
                    busy <= 1'b0;
                    if (!rxd) begin
                        data  <= shreg;
                        valid <= 1'b1;
                        state <= IDLE;
                    end else begin
                        frame_err <= 1'b1;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        // A line stuck at 1 must not look like a fresh start
                        // bit, so wait here for it to return to idle.
                        state <= RESYNC;
                    end
                end
                RESYNC: begin
                    if (!rxd) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fsm_rx.sv
// Testbench for fsm_rx.
// - The reference model builds each frame as a list of per-cycle steps. Each
//   step holds the line value to drive and the outputs expected one edge later.
// - Those expectations follow from the frame layout: start bit, data bits LSB
//   first, then the stop bit.
// - A second instance with DATA_BITS=5 covers the narrow build.
module tb_fsm_rx;

  localparam int N = 8;

  typedef struct packed {
    logic       rxd;
    logic       v;
    logic       f;
    logic       b;
    logic [7:0] d;
    logic [7:0] e;
  } step_t;

  logic         clk;
  logic         rst;
  logic         rxd;
  logic [N-1:0] data;
  logic         valid;
  logic         frame_err;
  logic         busy;
  logic [7:0]   err_cnt;
  logic [1:0]   state_dbg;

  logic         rxd5;
  logic [4:0]   data5;
  logic         valid5;
  logic         frame_err5;
  logic         busy5;
  logic [7:0]   err_cnt5;
  logic [1:0]   state_dbg5;

  step_t      exp_q[$];
  logic [7:0] model_data;
  logic [7:0] model_err;
  int         checks;
  int         failures;
  int         n_ferr_exp;
  int         n_ferr_obs;

  fsm_rx #(.DATA_BITS(N)) u_dut (
    .clk(clk), .rst(rst), .rxd(rxd), .data(data), .valid(valid),
    .frame_err(frame_err), .busy(busy), .err_cnt(err_cnt), .state_dbg(state_dbg)
  );

  fsm_rx #(.DATA_BITS(5)) u_dut5 (
    .clk(clk), .rst(rst), .rxd(rxd5), .data(data5), .valid(valid5),
    .frame_err(frame_err5), .busy(busy5), .err_cnt(err_cnt5), .state_dbg(state_dbg5)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model: frame builder
  task automatic push_step(input logic r, input logic v, input logic f, input logic b);
    step_t s;
    s.rxd = r;
    s.v   = v;
    s.f   = f;
    s.b   = b;
    s.d   = model_data;
    s.e   = model_err;
    exp_q.push_back(s);
  endtask

  task automatic add_frame(input logic [7:0] w, input bit bad, input int hold, input int gap);
    push_step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < N; i++) push_step(w[i], 1'b0, 1'b0, 1'b1);
    if (!bad) begin
      model_data = w;
      push_step(1'b0, 1'b1, 1'b0, 1'b0);
    end else begin
      if (model_err != 8'hFF) model_err = model_err + 8'd1;
      n_ferr_exp++;
      push_step(1'b1, 1'b0, 1'b1, 1'b0);
      repeat (hold) push_step(1'b1, 1'b0, 1'b0, 1'b0);
      push_step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    repeat (gap) push_step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // driver: one step per clock, drive on negedge, check 1 time unit after posedge
  task automatic run_stream();
    step_t s;
    while (exp_q.size() > 0) begin
      s = exp_q.pop_front();
      @(negedge clk);
      rxd = s.rxd;
      @(posedge clk);
      #1;
      if (frame_err === 1'b1) n_ferr_obs++;
      check("valid", 32'(valid), 32'(s.v));
      check("frame_err", 32'(frame_err), 32'(s.f));
      check("busy", 32'(busy), 32'(s.b));
      check("data", 32'(data), 32'(s.d));
      check("err_cnt", 32'(err_cnt), 32'(s.e));
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 32'(valid), 32'd0);
    check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_data"}, 32'(data), 32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
  endtask

  initial begin
    logic [7:0] w;
    logic [4:0] w5;
    checks     = 0;
    failures   = 0;
    n_ferr_exp = 0;
    n_ferr_obs = 0;
    model_data = 8'd0;
    model_err  = 8'd0;
    rst  = 1'b0;
    rxd  = 1'b0;
    rxd5 = 1'b0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk);
    rst = 1'b1;

    // single frame, back-to-back pair, framing error with stuck line, recovery frame
    add_frame(8'hA5, 1'b0, 0, 2);
    add_frame(8'h3C, 1'b0, 0, 0);
    add_frame(8'hFF, 1'b0, 0, 3);
    add_frame(8'h55, 1'b1, 5, 2);
    add_frame(8'h81, 1'b0, 0, 1);
    run_stream();

    // reset mid-frame: abandon frame 0xF0 after data bit 3
    w = 8'hF0;
    push_step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) push_step(w[i], 1'b0, 1'b0, 1'b1);
    run_stream();
    #2;
    rst = 1'b0;
    #1;
    check_reset_values("midreset");
    model_data = 8'd0;
    model_err  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("midreset_hold");
    @(negedge clk);
    rxd = 1'b0;
    rst = 1'b1;
    add_frame(8'h0F, 1'b0, 0, 1);
    run_stream();

    // randomized traffic
    for (int k = 0; k < 40; k++) begin
      add_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0),
                int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
    end
    run_stream();

    // saturation of err_cnt
    for (int k = 0; k < 260; k++) add_frame(8'($urandom_range(0, 255)), 1'b1, 0, 0);
    add_frame(8'h5A, 1'b0, 0, 1);
    run_stream();
    check("frame_err_pulses", 32'(n_ferr_obs), 32'(n_ferr_exp));

    // DATA_BITS=5 build: frame 0x13, valid six clocks after the start edge
    w5 = 5'h13;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) rxd5 = 1'b1;
      else if (k <= 5) rxd5 = w5[k-1];
      else rxd5 = 1'b0;
      @(posedge clk);
      #1;
      check("dw5_valid", 32'(valid5), (k == 6) ? 32'd1 : 32'd0);
      check("dw5_frame_err", 32'(frame_err5), 32'd0);
      if (k == 6) check("dw5_data", 32'(data5), 32'h13);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
